// File: rtl/emergency_request_arbiter.sv
// Emergency-vehicle request front end: synchronises and debounces four detector lines,
// then grants one approach at a time with round-robin order, a hold limit and a cooldown.
module emergency_request_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_HOLD_CYCLES = 64,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_raw,
    output logic [3:0] emergency,
    output logic       busy,
    output logic       timeout_pulse,
    output logic [3:0] locked
);

    // state    | meaning
    // IDLE     | no grant; waiting for an eligible filtered request
    // GRANT    | one approach granted; hold timer running
    // COOLDOWN | forced all-zero gap after a grant ends
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_CYCLES - 1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    filt;
    logic [DW-1:0] db_cnt [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= req_raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        filt[i]   <= ~filt[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [CW-1:0] cd_cnt;
    logic [CW-1:0] cd_next;
    logic [1:0]    last_ptr;
    logic [1:0]    last_next;
    logic [3:0]    emergency_next;
    logic          timeout_next;
    logic [3:0]    lock_set;
    logic [3:0]    eligible;
    logic [1:0]    cand;
    logic [1:0]    pick_idx;
    logic          pick_valid;

    assign eligible = filt & ~locked;

    // Rotation N(3)->E(2)->S(1)->W(0)->N walks downward from the last grant; the
    // last-granted approach itself is tried last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_ptr;
        cand       = last_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr - 2'(k);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next     = state;
        emergency_next = emergency;
        hold_next      = hold_cnt;
        cd_next        = cd_cnt;
        last_next      = last_ptr;
        timeout_next   = 1'b0;
        lock_set       = '0;
        case (state)
            IDLE: begin
                emergency_next = '0;
                if (pick_valid) begin
                    state_next     = GRANT;
                    emergency_next = 4'b0001 << pick_idx;
                    hold_next      = '0;
                    last_next      = pick_idx;
                end
            end
            GRANT: begin
                // A genuine release wins over a coincident timeout.
                if (!filt[last_ptr]) begin
                    state_next     = COOLDOWN;
                    emergency_next = '0;
                    cd_next        = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next         = COOLDOWN;
                    emergency_next     = '0;
                    cd_next            = '0;
                    timeout_next       = 1'b1;
                    lock_set[last_ptr] = 1'b1;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            COOLDOWN: begin
                emergency_next = '0;
                if (cd_cnt == CD_LAST) begin
                    state_next = IDLE;
                end else begin
                    cd_next = cd_cnt + 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                emergency_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            emergency     <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            locked        <= '0;
            hold_cnt      <= '0;
            cd_cnt        <= '0;
            last_ptr      <= 2'd0;
        end else begin
            state         <= state_next;
            emergency     <= emergency_next;
            busy          <= (state_next != IDLE);
            timeout_pulse <= timeout_next;
            locked        <= (locked & filt) | lock_set;
            hold_cnt      <= hold_next;
            cd_cnt        <= cd_next;
            last_ptr      <= last_next;
        end
    end

endmodule
